// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Byte-serial add sequencer. Adds two NBYTES-wide operands one byte at a time
// through a shared external combinational 8-bit adder that has no carry-in.
// A carry into a byte is handled by a second pass through the same adder:
// the byte sum is parked in r_partial, then incremented by one.
//
// Optional feature (macro SERIAL_ADD_SUB_EN):
//   adds input i_sub, sampled with i_start. With i_sub=1 the B bytes are
//   inverted and the chain starts with a carry, giving A-B. In that mode
//   o_carry_out=1 means no borrow (A>=B). Without the macro: add only.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      request pulse, accepted only while o_busy=0
//   i_op_a       operand A, sampled on accepted start
//   i_op_b       operand B, sampled on accepted start
//   i_sub        subtract select (SERIAL_ADD_SUB_EN only)
//   o_busy       high from the cycle after accepted start through DONE
//   o_done       one-cycle pulse; o_result/o_carry_out valid
//   o_result     sum, held until the next accepted start
//   o_carry_out  carry out of the MSB byte, held with o_result
//   o_add_a      shared adder input A
//   o_add_b      shared adder input B
//   i_add_sum    shared adder SUM (combinational)
//   i_add_carry  shared adder CARRY (combinational)
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [8*NBYTES-1:0]   i_op_a,
  input  logic [8*NBYTES-1:0]   i_op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                  i_sub,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic [8*NBYTES-1:0]   o_result,
  output logic                  o_carry_out,
  output logic [7:0]            o_add_a,
  output logic [7:0]            o_add_b,
  input  logic [7:0]            i_add_sum,
  input  logic                  i_add_carry
);

  // A single-byte build still needs a 1-bit index register.
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_INC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]          r_state;
  logic [8*NBYTES-1:0] r_opA;
  logic [8*NBYTES-1:0] r_opB;
  logic [IDXW-1:0]     r_idx;
  logic                r_c;
  logic                r_c1;
  logic [7:0]          r_partial;
  logic [8*NBYTES-1:0] r_result;
  logic                r_carryOut;
`ifdef SERIAL_ADD_SUB_EN
  logic                r_sub;
`endif

  logic [7:0] w_byteA;
  logic [7:0] w_byteB;
  logic       w_cNew;
  logic       w_startOk;

  // Current operand bytes; in subtract mode B is inverted so that
  // A + ~B + 1 forms the difference.
  always_comb begin
    w_byteA = r_opA[r_idx*8 +: 8];
    w_byteB = r_opB[r_idx*8 +: 8];
`ifdef SERIAL_ADD_SUB_EN
    if (r_sub) begin
      w_byteB = ~r_opB[r_idx*8 +: 8];
    end
`endif
  end

  // Carry leaving the current byte. After an increment pass either of the
  // two adder passes may have produced it (they never both do).
  assign w_cNew    = (r_state == ST_INC) ? (r_c1 | i_add_carry) : i_add_carry;
  assign w_startOk = i_start && (r_state == ST_IDLE);

  // Adder inputs are decoded straight from registered state; zero when idle.
  always_comb begin
    o_add_a = 8'h00;
    o_add_b = 8'h00;
    case (r_state)
      ST_ADD: begin
        o_add_a = w_byteA;
        o_add_b = w_byteB;
      end
      ST_INC: begin
        o_add_a = r_partial;
        o_add_b = 8'h01;
      end
      default: begin
        o_add_a = 8'h00;
        o_add_b = 8'h00;
      end
    endcase
  end

  // Sequencer: ADD handles a byte with no incoming carry in one pass; a byte
  // entered with carry takes ADD then INC. Result bytes are written in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_idx      <= '0;
      r_c        <= 1'b0;
      r_c1       <= 1'b0;
      r_partial  <= 8'h00;
      r_result   <= '0;
      r_carryOut <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      r_sub      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_startOk) begin
            r_opA   <= i_op_a;
            r_opB   <= i_op_b;
            r_idx   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            r_sub   <= i_sub;
            r_c     <= i_sub;
`else
            r_c     <= 1'b0;
`endif
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (!r_c) begin
            r_result[r_idx*8 +: 8] <= i_add_sum;
            r_c <= w_cNew;
            if (r_idx == LAST_IDX) begin
              r_carryOut <= w_cNew;
              r_state    <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDXW'(1);
              r_state <= ST_ADD;
            end
          end else begin
            r_partial <= i_add_sum;
            r_c1      <= i_add_carry;
            r_state   <= ST_INC;
          end
        end
        ST_INC: begin
          r_result[r_idx*8 +: 8] <= i_add_sum;
          r_c <= w_cNew;
          if (r_idx == LAST_IDX) begin
            r_carryOut <= w_cNew;
            r_state    <= ST_DONE;
          end else begin
            r_idx   <= r_idx + IDXW'(1);
            r_state <= ST_ADD;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_result    = r_result;
  assign o_carry_out = r_carryOut;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Testbench for serial_add_ctrl (NBYTES=4) with a behavioural model of the
// external 8-bit adder. Build with +define+SERIAL_ADD_SUB_EN to also cover
// subtract mode.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int NB = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] expResult;
    logic        expCarry;
    int          expLat;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        c;
    int          lat;
    int          startCycle;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carryOut;
  logic [7:0]  addA;
  logic [7:0]  addB;
  logic [7:0]  addSum;
  logic        addCarry;

  int   total = 0;
  int   bad = 0;
  int   cycleCnt = 0;
  exp_t sbq[$];
  vec_t vecs[9];

  serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(start),
    .i_op_a(opA),
    .i_op_b(opB),
`ifdef SERIAL_ADD_SUB_EN
    .i_sub(sub),
`endif
    .o_busy(busy),
    .o_done(done),
    .o_result(result),
    .o_carry_out(carryOut),
    .o_add_a(addA),
    .o_add_b(addB),
    .i_add_sum(addSum),
    .i_add_carry(addCarry)
  );

  // External shared adder: plain 8-bit add, no carry-in.
  assign {addCarry, addSum} = {1'b0, addA} + {1'b0, addB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Byte-level reference: result, carry and the number of bytes that need
  // an increment pass (bytes entered with an incoming carry).
  function automatic exp_t modelOp(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [8:0]  t;
    logic        c;
    logic [31:0] bb;
    int          k;
    bb = s ? ~b : b;
    c = s;
    k = 0;
    e.r = '0;
    for (int i = 0; i < NB; i++) begin
      if (c) k++;
      t = {1'b0, a[i*8 +: 8]} + {1'b0, bb[i*8 +: 8]} + {8'd0, c};
      e.r[i*8 +: 8] = t[7:0];
      c = t[8];
    end
    e.c = c;
    e.lat = NB + 1 + k;
    e.startCycle = 0;
    return e;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one request and records the expected outcome in the scoreboard.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic [31:0] expR, input logic expC, input int expLat);
    exp_t e;
    @(negedge clk);
    opA = a;
    opB = b;
    sub = s;
    start = 1'b1;
    e.r = expR;
    e.c = expC;
    e.lat = expLat;
    e.startCycle = cycleCnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done, checking busy stays high, then pops and compares.
  task automatic checkOutput(input int budget);
    int   waited;
    logic busyOk;
    exp_t e;
    waited = 0;
    busyOk = 1'b1;
    while (done !== 1'b1 && waited < budget) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk);
      #1;
      waited++;
    end
    checkValue("busyWhileRunning", {31'd0, busyOk}, 32'd1);
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL doneTimeout: got no done after %0d cycles expected done", budget);
      if (sbq.size() > 0) void'(sbq.pop_front());
      return;
    end
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpectedDone: got done expected no pending request");
      return;
    end
    e = sbq.pop_front();
    checkValue("result", result, e.r);
    checkValue("carryOut", {31'd0, carryOut}, {31'd0, e.c});
    checkValue("latency", cycleCnt - e.startCycle, e.lat);
    checkValue("busyAtDone", {31'd0, busy}, 32'd1);
  endtask

  // After the done cycle the block must be idle again.
  task automatic checkIdleAfterDone();
    @(posedge clk);
    #1;
    checkValue("doneOneCycle", {31'd0, done}, 32'd0);
    checkValue("busyAfterDone", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic doneSeen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic rs;

    vecs[0] = '{32'h00000064, 32'h00000078, 1'b0, 32'h000000DC, 1'b0, 5};
    vecs[1] = '{32'h000000FF, 32'h00000002, 1'b0, 32'h00000101, 1'b0, 6};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 8};
    vecs[3] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 5};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 5};
    vecs[5] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 5};
    vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 7};
    vecs[7] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 6};
    vecs[8] = '{32'h00000007, 32'h00000005, 1'b1, 32'h00000002, 1'b1, 9};

    rst_n = 1'b1;
    start = 1'b0;
    opA = '0;
    opB = '0;
    sub = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("resetBusy", {31'd0, busy}, 32'd0);
    checkValue("resetDone", {31'd0, done}, 32'd0);
    checkValue("resetResult", result, 32'd0);
    checkValue("resetCarry", {31'd0, carryOut}, 32'd0);
    checkValue("resetAddA", {24'd0, addA}, 32'd0);
    checkValue("resetAddB", {24'd0, addB}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
`ifndef SERIAL_ADD_SUB_EN
      if (vecs[i].sub) continue;
`endif
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub,
                    vecs[i].expResult, vecs[i].expCarry, vecs[i].expLat);
      checkOutput(3*NB + 10);
      checkIdleAfterDone();
    end

    $display("[TB] random vectors");
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = ~ra + 32'd1;
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      e = modelOp(ra, rb, rs);
      applyStimulus(ra, rb, rs, e.r, e.c, e.lat);
      checkOutput(3*NB + 10);
      checkIdleAfterDone();
    end

    $display("[TB] start while busy and in DONE cycle");
    applyStimulus(32'h00000064, 32'h00000078, 1'b0, 32'h000000DC, 1'b0, 5);
    @(posedge clk);
    #1;
    @(negedge clk);
    opA = 32'h11111111;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput(3*NB + 10);
    @(negedge clk);
    opA = 32'h22222222;
    opB = 32'h00000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkValue("startInDoneIgnoredBusy", {31'd0, busy}, 32'd0);
    checkValue("startInDoneIgnoredResult", result, 32'h000000DC);
    applyStimulus(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 5);
    checkOutput(3*NB + 10);
    checkIdleAfterDone();

    $display("[TB] reset mid-operation");
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 8);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("midResetBusy", {31'd0, busy}, 32'd0);
    checkValue("midResetDone", {31'd0, done}, 32'd0);
    checkValue("midResetResult", result, 32'd0);
    checkValue("midResetCarry", {31'd0, carryOut}, 32'd0);
    checkValue("midResetAddA", {24'd0, addA}, 32'd0);
    checkValue("midResetAddB", {24'd0, addB}, 32'd0);
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) doneSeen = 1'b1;
    end
    checkValue("noDoneAfterReset", {31'd0, doneSeen}, 32'd0);
    applyStimulus(32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 5);
    checkOutput(3*NB + 10);
    checkIdleAfterDone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
